// File: rtl/sim_ctrl_pkg.sv
// rtl/sim_ctrl_pkg.sv - shared types for the simulation controller
package sim_ctrl_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_DONE    = 2'd1,
      CAUSE_TIMEOUT = 2'd2,
      CAUSE_STALL   = 2'd3
   } cause_e;

endpackage

// File: rtl/sim_sat_counter.sv
// rtl/sim_sat_counter.sv - saturating up-counter with synchronous clear
// Clear wins over increment; the count holds at all-ones instead of wrapping.
module sim_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_q
);

   logic [CNT_W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_inc && (r_q != '1)) begin
         r_q <= r_q + CNT_W'(1);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - bench reset sequencer, run cycle counter and end-of-test watchdog
// Holds the DUT in reset, counts RUN cycles and latches exactly one end cause in DONE.
module sim_ctrl
   import sim_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = 5,
   parameter int TIMEOUT      = 100000,
   parameter int IDLE_LIMIT   = 1000,
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             soft_rst_req,
   input  logic             heartbeat,
   input  logic             halt_req,
   output logic             core_rst,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [1:0]       state_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic             stall_o
);

   if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("sim_ctrl: RESET_CYCLES must be >= 1");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("sim_ctrl: TIMEOUT must be >= 1");
   end

   localparam logic [CNT_W-1:0] L_RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_IDLE_LAST    = CNT_W'((IDLE_LIMIT > 0) ? IDLE_LIMIT - 1 : 0);
   localparam logic [CNT_W-1:0] L_DRAIN_LAST   = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   state_e           r_state;
   logic             r_core_rst;
   logic             r_done;
   logic             r_timeout;
   logic             r_stall;

   state_e           w_next;
   cause_e           w_cause;
   logic [CNT_W-1:0] w_cycle;
   logic [CNT_W-1:0] w_idle;
   logic [CNT_W-1:0] w_phase;
   logic             w_timeout_hit;
   logic             w_stall_hit;
   logic             w_cycle_clr;
   logic             w_cycle_inc;
   logic             w_idle_clr;
   logic             w_idle_inc;
   logic             w_phase_clr;
   logic             w_phase_inc;

   assign w_timeout_hit = (w_cycle == L_TIMEOUT_LAST);
   // The current idle cycle counts too, so a heartbeat now still rescues the run.
   assign w_stall_hit   = (IDLE_LIMIT > 0) && !heartbeat && (w_idle == L_IDLE_LAST);

   always_comb begin
      w_next  = r_state;
      w_cause = CAUSE_NONE;
      if (soft_rst_req) begin
         w_next = RESET;
      end else begin
         case (r_state)
            RESET: begin
               if (w_phase == L_RESET_LAST) w_next = RUN;
            end
            RUN: begin
               if (w_timeout_hit) begin
                  w_next  = DONE;
                  w_cause = CAUSE_TIMEOUT;
               end else if (w_stall_hit) begin
                  w_next  = DONE;
                  w_cause = CAUSE_STALL;
               end else if (halt_req) begin
                  if (DRAIN_CYCLES == 0) begin
                     w_next  = DONE;
                     w_cause = CAUSE_DONE;
                  end else begin
                     w_next = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_timeout_hit) begin
                  w_next  = DONE;
                  w_cause = CAUSE_TIMEOUT;
               end else if (w_phase == L_DRAIN_LAST) begin
                  w_next  = DONE;
                  w_cause = CAUSE_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // cycle_cnt freezes on the edge into DONE, so it reports the last counted cycle.
   assign w_cycle_clr = (w_next == RESET);
   assign w_cycle_inc = ((r_state == RUN) || (r_state == DRAIN)) &&
                        ((w_next == RUN) || (w_next == DRAIN));
   assign w_idle_clr  = (w_next != RUN) || heartbeat;
   assign w_idle_inc  = (r_state == RUN);
   assign w_phase_clr = (w_next != r_state) || soft_rst_req;
   assign w_phase_inc = (r_state == RESET) || (r_state == DRAIN);

   sim_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_cycle_clr),
      .i_inc (w_cycle_inc),
      .o_q   (w_cycle)
   );

   sim_sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_idle_clr),
      .i_inc (w_idle_inc),
      .o_q   (w_idle)
   );

   sim_sat_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_phase_clr),
      .i_inc (w_phase_inc),
      .o_q   (w_phase)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RESET;
         r_core_rst <= 1'b1;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_stall    <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_core_rst <= (w_next == RESET);
         if (soft_rst_req) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_stall   <= 1'b0;
         end else begin
            if (w_cause == CAUSE_DONE)    r_done    <= 1'b1;
            if (w_cause == CAUSE_TIMEOUT) r_timeout <= 1'b1;
            if (w_cause == CAUSE_STALL)   r_stall   <= 1'b1;
         end
      end
   end

   assign core_rst  = r_core_rst;
   assign cycle_cnt = w_cycle;
   assign state_o   = r_state;
   assign done_o    = r_done;
   assign timeout_o = r_timeout;
   assign stall_o   = r_stall;

endmodule

// File: tb/tb_sim_ctrl.sv
// tb/tb_sim_ctrl.sv - directed self-checking bench for sim_ctrl
module tb_sim_ctrl;

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        soft_rst_req;
   logic        heartbeat;
   logic        halt_req;
   logic        core_rst;
   logic [31:0] cycle_cnt;
   logic [1:0]  state_o;
   logic        done_o;
   logic        timeout_o;
   logic        stall_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sim_ctrl #(
      .RESET_CYCLES (5),
      .TIMEOUT      (50),
      .IDLE_LIMIT   (10),
      .DRAIN_CYCLES (4),
      .CNT_W        (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .soft_rst_req (soft_rst_req),
      .heartbeat    (heartbeat),
      .halt_req     (halt_req),
      .core_rst     (core_rst),
      .cycle_cnt    (cycle_cnt),
      .state_o      (state_o),
      .done_o       (done_o),
      .timeout_o    (timeout_o),
      .stall_o      (stall_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic crst,
                            input logic [31:0] cnt, input logic dn, input logic to, input logic sl);
      check({tag, "_state"},    32'(state_o),   32'(st));
      check({tag, "_core_rst"}, 32'(core_rst),  32'(crst));
      check({tag, "_cycle"},    cycle_cnt,      cnt);
      check({tag, "_done"},     32'(done_o),    32'(dn));
      check({tag, "_timeout"},  32'(timeout_o), 32'(to));
      check({tag, "_stall"},    32'(stall_o),   32'(sl));
   endtask

   // Called at the negedge where the controller sits in RESET with phase 0.
   task automatic expect_reset_seq(input string tag);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check({tag, "_hold"}, 32'(core_rst), 32'd1);
      end
      step(1);
      check_all({tag, "_run"}, ST_RUN, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic soft_reset(input string tag);
      soft_rst_req = 1'b1;
      step(1);
      soft_rst_req = 1'b0;
      check_all({tag, "_soft"}, ST_RESET, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      expect_reset_seq(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      soft_rst_req = 1'b0;
      heartbeat    = 1'b0;
      halt_req     = 1'b0;

      step(3);
      check_all("por", ST_RESET, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      rst       = 1'b0;
      heartbeat = 1'b1;
      expect_reset_seq("rst_release");
      step(3);
      check("count_3", cycle_cnt, 32'd3);

      // halt at cycle 20, four drain cycles, frozen at 24
      step(17);
      check("pre_halt_cnt", cycle_cnt, 32'd20);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      check_all("drain_enter", ST_DRAIN, 1'b0, 32'd21, 1'b0, 1'b0, 1'b0);
      step(3);
      check_all("drain_last", ST_DRAIN, 1'b0, 32'd24, 1'b0, 1'b0, 1'b0);
      step(1);
      check_all("halt_done", ST_DONE, 1'b0, 32'd24, 1'b1, 1'b0, 1'b0);
      step(5);
      check_all("done_sticky", ST_DONE, 1'b0, 32'd24, 1'b1, 1'b0, 1'b0);

      // timeout with continuous heartbeat
      soft_reset("to");
      step(49);
      check_all("to_pre", ST_RUN, 1'b0, 32'd49, 1'b0, 1'b0, 1'b0);
      step(1);
      check_all("to_hit", ST_DONE, 1'b0, 32'd49, 1'b0, 1'b1, 1'b0);
      step(3);
      check("to_frozen", cycle_cnt, 32'd49);

      // heartbeat stops at cycle 30 -> stall after 10 idle cycles
      soft_reset("stall");
      step(30);
      check("stall_hb_stop", cycle_cnt, 32'd30);
      heartbeat = 1'b0;
      step(9);
      check_all("stall_pre", ST_RUN, 1'b0, 32'd39, 1'b0, 1'b0, 1'b0);
      step(1);
      check_all("stall_hit", ST_DONE, 1'b0, 32'd39, 1'b0, 1'b0, 1'b1);
      heartbeat = 1'b1;

      // soft reset beats halt in the same cycle
      soft_reset("prio");
      step(15);
      check("prio_cnt", cycle_cnt, 32'd15);
      soft_rst_req = 1'b1;
      halt_req     = 1'b1;
      step(1);
      soft_rst_req = 1'b0;
      halt_req     = 1'b0;
      check_all("prio_soft", ST_RESET, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      expect_reset_seq("prio");
      step(3);
      check("prio_recount", cycle_cnt, 32'd3);

      // async rst in DRAIN
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      step(1);
      check("rst_drain_pre", 32'(state_o), 32'(ST_DRAIN));
      #2;
      rst = 1'b1;
      #1;
      check_all("rst_drain_async", ST_RESET, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      step(2);
      rst = 1'b0;
      expect_reset_seq("rst_drain");

      // async rst in DONE
      step(2);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      step(4);
      check_all("done2", ST_DONE, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_all("rst_done_async", ST_RESET, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      step(2);
      rst = 1'b0;
      expect_reset_seq("rst_done");
      step(2);
      check("final_cnt", cycle_cnt, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
